// File: rtl/l2_bus_arbiter_if.sv
// Request/grant bundle between the L1 miss handlers, the L2 bus arbiter and the L2 port.
// The arbiter uses the master view; the cache/L2 side uses the slave view.
interface l2_bus_arbiter_if;
  logic        ic_rd_req;
  logic [31:0] ic_addr;
  logic        dc_rd_req;
  logic        dc_wr_req;
  logic [31:0] dc_addr;
  logic [31:0] dc_wr_data;
  logic        l2_ready;
  logic        ic_rd_granted;
  logic        dc_rd_granted;
  logic        dc_wr_granted;
  logic [31:0] l2_addr;
  logic        l2_rd_en;
  logic        l2_wr_en;
  logic [31:0] l2_wr_data;
  logic        busy;

  modport master (
    input  ic_rd_req, ic_addr, dc_rd_req, dc_wr_req, dc_addr, dc_wr_data, l2_ready,
    output ic_rd_granted, dc_rd_granted, dc_wr_granted, l2_addr, l2_rd_en, l2_wr_en,
           l2_wr_data, busy
  );

  modport slave (
    output ic_rd_req, ic_addr, dc_rd_req, dc_wr_req, dc_addr, dc_wr_data, l2_ready,
    input  ic_rd_granted, dc_rd_granted, dc_wr_granted, l2_addr, l2_rd_en, l2_wr_en,
           l2_wr_data, busy
  );
endinterface

// File: rtl/l2_bus_arbiter.sv
// Arbitrates I-cache reads, D-cache reads and D-cache write-throughs onto one L2 port.
// Bursts run to completion; IC and DC alternate on contention, DC writes beat DC reads.
module l2_bus_arbiter #(
  parameter int RD_BURST_LEN = 4,
  parameter int WR_BURST_LEN = 1
) (
  input  logic             clk,
  input  logic             rst,
  l2_bus_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, IC_RD, DC_RD, DC_WR} state_t;

  localparam logic [2:0] RD_LAST = 3'(RD_BURST_LEN - 1);
  localparam logic [2:0] WR_LAST = 3'(WR_BURST_LEN - 1);

  state_t     state;
  logic [2:0] beat_cnt;
  logic       last_owner;

  logic ic_pending;
  logic dc_pending;
  logic owner_req;
  logic burst_last;
  logic beat_done;

  assign ic_pending = bus.ic_rd_req;
  assign dc_pending = bus.dc_rd_req | bus.dc_wr_req;

  always_comb begin
    owner_req  = 1'b0;
    burst_last = 1'b0;
    case (state)
      IC_RD: begin
        owner_req  = bus.ic_rd_req;
        burst_last = (beat_cnt == RD_LAST);
      end
      DC_RD: begin
        owner_req  = bus.dc_rd_req;
        burst_last = (beat_cnt == RD_LAST);
      end
      DC_WR: begin
        owner_req  = bus.dc_wr_req;
        burst_last = (beat_cnt == WR_LAST);
      end
      default: ;
    endcase
  end

  assign beat_done = (state != IDLE) && owner_req && bus.l2_ready;

  // A dropped request ends the burst just like its final beat does, so both hand
  // the bus back through IDLE and record who owned it for the round-robin.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      last_owner <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          beat_cnt <= '0;
          if (ic_pending && (!dc_pending || last_owner)) state <= IC_RD;
          else if (bus.dc_wr_req)                        state <= DC_WR;
          else if (bus.dc_rd_req)                        state <= DC_RD;
        end
        default: begin
          if (!owner_req || (bus.l2_ready && burst_last)) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            last_owner <= (state != IC_RD);
          end else if (bus.l2_ready) begin
            beat_cnt <= beat_cnt + 3'd1;
          end
        end
      endcase
    end
  end

  // Outputs decode the current state and are forced quiet while reset is held,
  // so a burst interrupted by reset cannot leak a grant in the reset cycle.
  always_comb begin
    bus.ic_rd_granted = 1'b0;
    bus.dc_rd_granted = 1'b0;
    bus.dc_wr_granted = 1'b0;
    bus.l2_addr       = '0;
    bus.l2_rd_en      = 1'b0;
    bus.l2_wr_en      = 1'b0;
    bus.l2_wr_data    = '0;
    bus.busy          = 1'b0;
    if (!rst) begin
      bus.busy = (state != IDLE);
      case (state)
        IC_RD: begin
          bus.l2_rd_en      = 1'b1;
          bus.l2_addr       = bus.ic_addr;
          bus.ic_rd_granted = beat_done;
        end
        DC_RD: begin
          bus.l2_rd_en      = 1'b1;
          bus.l2_addr       = bus.dc_addr;
          bus.dc_rd_granted = beat_done;
        end
        DC_WR: begin
          bus.l2_wr_en      = 1'b1;
          bus.l2_addr       = bus.dc_addr;
          bus.l2_wr_data    = bus.dc_wr_data;
          bus.dc_wr_granted = beat_done;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_bus_arbiter.sv
// Scoreboard bench for l2_bus_arbiter: stimulus queues expected grants and output states,
// a negedge monitor pops and compares them as the arbiter presents each cycle.
module tb_l2_bus_arbiter;

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] val;
    int          cyc;
  } chk_t;

  localparam int SEL_BUSY  = 0;
  localparam int SEL_RD    = 1;
  localparam int SEL_WR    = 2;
  localparam int SEL_ADDR  = 3;
  localparam int SEL_WDATA = 4;
  localparam int SEL_GNT   = 5;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  chk_t chk_q[$];

  int          ic_left;
  int          dcr_left;
  int          dcw_left;
  logic [31:0] ic_addr_v;
  logic [31:0] dcr_addr_v;
  logic [31:0] dcw_addr_v;
  logic        g_ic;
  logic        g_dr;
  logic        g_dw;

  l2_bus_arbiter_if bus ();

  l2_bus_arbiter #(.RD_BURST_LEN(4), .WR_BURST_LEN(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] sample_out(int sel);
    case (sel)
      SEL_BUSY:  return 32'(bus.busy);
      SEL_RD:    return 32'(bus.l2_rd_en);
      SEL_WR:    return 32'(bus.l2_wr_en);
      SEL_ADDR:  return bus.l2_addr;
      SEL_WDATA: return bus.l2_wr_data;
      default:   return {29'd0, bus.dc_wr_granted, bus.dc_rd_granted, bus.ic_rd_granted};
    endcase
  endfunction

  task automatic compare(string name, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: expire overdue grants, then match this cycle's grant and queued state checks.
  always @(negedge clk) begin
    exp_t       e;
    chk_t       c;
    logic [2:0] grants;
    grants = {bus.dc_wr_granted, bus.dc_rd_granted, bus.ic_rd_granted};
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL missing_grant: no grant by cycle %0d, required kind %0d at cycle %0d",
               cyc, e.kind, e.cyc);
    end
    compare("one_grant", 32'($onehot0(grants)), 32'd1);
    compare("rd_wr_excl", 32'(bus.l2_rd_en & bus.l2_wr_en), 32'd0);
    if (grants != 3'b000) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL unexpected_grant: got grants=%b at cycle %0d, required none",
                 grants, cyc);
      end else begin
        e = exp_q.pop_front();
        compare("grant_kind", 32'(grants), 32'(3'b001 << e.kind));
        compare("grant_cycle", cyc, e.cyc);
        compare("grant_addr", bus.l2_addr, e.addr);
        compare("grant_strobes", 32'({bus.l2_rd_en, bus.l2_wr_en}),
                (e.kind == 2'd2) ? 32'd1 : 32'd2);
        if (e.kind == 2'd2) compare("grant_wr_data", bus.l2_wr_data, e.data);
      end
    end
    while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
      c = chk_q.pop_front();
      if (c.cyc < cyc) begin
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL %s: got no sample, required %h at cycle %0d", c.name, c.val, c.cyc);
      end else begin
        compare(c.name, sample_out(c.sel), c.val);
      end
    end
  end

  task automatic apply_stimulus();
    bus.ic_rd_req = (ic_left > 0);
    bus.ic_addr   = ic_addr_v;
    bus.dc_wr_req = (dcw_left > 0);
    bus.dc_rd_req = (dcr_left > 0);
    bus.dc_addr   = (dcw_left > 0) ? dcw_addr_v : dcr_addr_v;
  endtask

  task automatic check_output(string name, int sel, logic [31:0] val);
    chk_t c;
    c.name = name;
    c.sel  = sel;
    c.val  = val;
    c.cyc  = cyc;
    chk_q.push_back(c);
  endtask

  task automatic expect_zero(string tag);
    check_output({tag, "_busy"},   SEL_BUSY,  32'd0);
    check_output({tag, "_rd_en"},  SEL_RD,    32'd0);
    check_output({tag, "_wr_en"},  SEL_WR,    32'd0);
    check_output({tag, "_addr"},   SEL_ADDR,  32'd0);
    check_output({tag, "_wdata"},  SEL_WDATA, 32'd0);
    check_output({tag, "_grants"}, SEL_GNT,   32'd0);
  endtask

  task automatic push_grant(logic [1:0] kind, logic [31:0] addr, logic [31:0] data, int c);
    exp_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  // One clock: the miss handlers see this cycle's grants, then advance just after the edge.
  task automatic step();
    @(negedge clk);
    g_ic = bus.ic_rd_granted;
    g_dr = bus.dc_rd_granted;
    g_dw = bus.dc_wr_granted;
    @(posedge clk);
    #1;
    if (g_ic && ic_left > 0) begin
      ic_left--;
      ic_addr_v += 32'd4;
    end
    if (g_dr && dcr_left > 0) begin
      dcr_left--;
      dcr_addr_v += 32'd4;
    end
    if (g_dw && dcw_left > 0) dcw_left--;
    apply_stimulus();
  endtask

  task automatic start_ic(int beats, logic [31:0] addr);
    ic_left   = beats;
    ic_addr_v = addr;
    apply_stimulus();
  endtask

  task automatic start_dcrd(int beats, logic [31:0] addr);
    dcr_left   = beats;
    dcr_addr_v = addr;
    apply_stimulus();
  endtask

  task automatic start_dcwr(int beats, logic [31:0] addr, logic [31:0] data);
    dcw_left       = beats;
    dcw_addr_v     = addr;
    bus.dc_wr_data = data;
    apply_stimulus();
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (exp_q.size() > 0 || chk_q.size() > 0); i++) step();
    step();
  endtask

  task automatic do_reset(string tag);
    rst = 1'b1;
    expect_zero(tag);
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    bit ready_seq [6];
    int s;
    ready_seq  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    rst        = 1'b1;
    ic_left    = 0;
    dcr_left   = 0;
    dcw_left   = 0;
    ic_addr_v  = '0;
    dcr_addr_v = '0;
    dcw_addr_v = '0;
    g_ic       = 1'b0;
    g_dr       = 1'b0;
    g_dw       = 1'b0;
    bus.l2_ready   = 1'b1;
    bus.dc_wr_data = '0;
    apply_stimulus();
    step();
    step();
    expect_zero("in_reset");
    rst = 1'b0;
    step();
    expect_zero("after_reset");

    // Lone IC burst: four back-to-back grants, then a single IDLE cycle.
    step();
    s = cyc;
    start_ic(4, 32'h0000_1000);
    for (int i = 0; i < 4; i++) push_grant(2'd0, 32'h0000_1000 + 32'(4 * i), 32'd0, s + 1 + i);
    while (cyc < s + 5) step();
    check_output("s1_idle_busy", SEL_BUSY, 32'd0);
    check_output("s1_idle_rd_en", SEL_RD, 32'd0);
    drain();

    // Simultaneous IC/DC after reset: IC first, then DC; repeating hands IC the bus again.
    do_reset("pre_rr");
    s = cyc;
    start_ic(4, 32'h0000_2000);
    start_dcrd(4, 32'h0000_3000);
    for (int i = 0; i < 4; i++) push_grant(2'd0, 32'h0000_2000 + 32'(4 * i), 32'd0, s + 1 + i);
    for (int i = 0; i < 4; i++) push_grant(2'd1, 32'h0000_3000 + 32'(4 * i), 32'd0, s + 6 + i);
    while (cyc < s + 5) step();
    check_output("rr_gap_busy", SEL_BUSY, 32'd0);
    check_output("rr_gap_addr", SEL_ADDR, 32'd0);
    drain();
    s = cyc;
    start_ic(4, 32'h0000_2100);
    start_dcrd(4, 32'h0000_3100);
    for (int i = 0; i < 4; i++) push_grant(2'd0, 32'h0000_2100 + 32'(4 * i), 32'd0, s + 1 + i);
    for (int i = 0; i < 4; i++) push_grant(2'd1, 32'h0000_3100 + 32'(4 * i), 32'd0, s + 6 + i);
    drain();

    // DC write beats DC read; the read burst follows after one IDLE cycle.
    s = cyc;
    start_dcwr(1, 32'h0000_4000, 32'hDEAD_BEEF);
    start_dcrd(4, 32'h0000_5000);
    push_grant(2'd2, 32'h0000_4000, 32'hDEAD_BEEF, s + 1);
    for (int i = 0; i < 4; i++) push_grant(2'd1, 32'h0000_5000 + 32'(4 * i), 32'd0, s + 3 + i);
    while (cyc < s + 2) step();
    check_output("wr_gap_busy", SEL_BUSY, 32'd0);
    drain();

    // IC burst with l2_ready pattern 1,0,0,1,1,1: address holds while stalled.
    s = cyc;
    start_ic(4, 32'h0000_6000);
    push_grant(2'd0, 32'h0000_6000, 32'd0, s + 1);
    push_grant(2'd0, 32'h0000_6004, 32'd0, s + 4);
    push_grant(2'd0, 32'h0000_6008, 32'd0, s + 5);
    push_grant(2'd0, 32'h0000_600C, 32'd0, s + 6);
    for (int i = 0; i < 6; i++) begin
      step();
      bus.l2_ready = ready_seq[i];
      if (!ready_seq[i]) begin
        check_output("stall_addr", SEL_ADDR, 32'h0000_6004);
        check_output("stall_rd_en", SEL_RD, 32'd1);
      end
    end
    bus.l2_ready = 1'b1;
    drain();

    // DC read abandoned after two beats while IC waits; IC takes the bus afterwards.
    s = cyc;
    start_dcrd(4, 32'h0000_7000);
    push_grant(2'd1, 32'h0000_7000, 32'd0, s + 1);
    push_grant(2'd1, 32'h0000_7004, 32'd0, s + 2);
    for (int i = 0; i < 4; i++) push_grant(2'd0, 32'h0000_A000 + 32'(4 * i), 32'd0, s + 5 + i);
    step();
    start_ic(4, 32'h0000_A000);
    while (cyc < s + 3) step();
    dcr_left = 0;
    apply_stimulus();
    check_output("drop_busy_held", SEL_BUSY, 32'd1);
    step();
    check_output("drop_busy_idle", SEL_BUSY, 32'd0);
    drain();

    // Reset after the second beat of a DC read, then a fresh full burst.
    s = cyc;
    start_dcrd(4, 32'h0000_8000);
    push_grant(2'd1, 32'h0000_8000, 32'd0, s + 1);
    push_grant(2'd1, 32'h0000_8004, 32'd0, s + 2);
    while (cyc < s + 3) step();
    rst      = 1'b1;
    dcr_left = 0;
    apply_stimulus();
    expect_zero("rst_mid_burst");
    step();
    expect_zero("rst_next");
    rst = 1'b0;
    step();
    s = cyc;
    start_dcrd(4, 32'h0000_9000);
    for (int i = 0; i < 4; i++) push_grant(2'd1, 32'h0000_9000 + 32'(4 * i), 32'd0, s + 1 + i);
    drain();

    step();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/l2_bus_arbiter.md
L2_BUS_ARBITER -- requirements
Module: l2_bus_arbiter

Interface
REQ-001 Parameter: RD_BURST_LEN, default 4, number of 32-bit beats per read burst; legal values 1..8.
REQ-002 Parameter: WR_BURST_LEN, default 1, number of 32-bit beats per write; legal values 1..8.
REQ-003 Port: clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 Port: rst  in  1  reset, synchronous and active-high.
REQ-005 Port: ic_rd_req  in  1  I-cache miss handler read request; held high for the whole burst.
REQ-006 Port: ic_addr  in  32  I-cache beat address; the handler advances it after each grant.
REQ-007 Port: dc_rd_req  in  1  D-cache miss handler read request; held high for the whole burst.
REQ-008 Port: dc_wr_req  in  1  D-cache write-through request.
REQ-009 Port: dc_addr  in  32  D-cache beat address.
REQ-010 Port: dc_wr_data  in  32  D-cache write data.
REQ-011 Port: l2_ready  in  1  L2 accepts or returns one beat this cycle.
REQ-012 Port: ic_rd_granted  out  1  one-cycle pulse per completed I-cache read beat.
REQ-013 Port: dc_rd_granted  out  1  one-cycle pulse per completed D-cache read beat.
REQ-014 Port: dc_wr_granted  out  1  one-cycle pulse per completed D-cache write beat.
REQ-015 Port: l2_addr  out  32  address driven to L2.
REQ-016 Port: l2_rd_en  out  1  L2 read strobe.
REQ-017 Port: l2_wr_en  out  1  L2 write strobe.
REQ-018 Port: l2_wr_data  out  32  L2 write data.
REQ-019 Port: busy  out  1  arbiter state is not IDLE.

Function
REQ-020 The FSM SHALL use the states IDLE, IC_RD, DC_RD and DC_WR, with registered state, a registered beat counter beat_cnt[2:0] and a registered last_owner bit (0 = IC, 1 = DC).
REQ-021 In IDLE, the highest-priority pending request SHALL be chosen and the FSM SHALL enter its state on the next edge, with beat_cnt cleared.
REQ-022 Priority among D-cache requests SHALL be dc_wr_req over dc_rd_req.
REQ-023 Between IC and DC, priority SHALL be round-robin: the requester not equal to last_owner wins when both request; a single requester always wins.
REQ-024 With no requests, the FSM SHALL remain in IDLE with all strobes low.
REQ-025 Outputs SHALL be combinational from the state.
- IC_RD: l2_rd_en = 1, l2_addr = ic_addr.
- DC_RD: l2_rd_en = 1, l2_addr = dc_addr.
- DC_WR: l2_wr_en = 1, l2_addr = dc_addr, l2_wr_data = dc_wr_data.
- IDLE: l2_addr = 0, l2_wr_data = 0.
REQ-026 A beat SHALL complete when the FSM is in a non-IDLE state, the owning request is high and l2_ready = 1; the matching *_granted output SHALL be 1 in that same cycle only.
REQ-027 On each completed beat, beat_cnt SHALL increment; when beat_cnt equals burst length - 1, the completing beat SHALL return the FSM to IDLE, clear beat_cnt and set last_owner to the owner.
REQ-028 When l2_ready = 0, the FSM and beat_cnt SHALL hold; there is no timeout.
REQ-029 If the owning request drops mid-burst, the FSM SHALL return to IDLE next edge, clear beat_cnt, assert no grant that cycle and update last_owner.
REQ-030 There SHALL be exactly one IDLE cycle between consecutive bursts; back-to-back bursts to the same requester are permitted when no other requester is pending.
REQ-031 A burst in progress SHALL NOT be pre-empted by any other request.
REQ-032 At most one *_granted output SHALL be high in any cycle, and l2_rd_en and l2_wr_en SHALL never both be high.

Reset
REQ-033 When rst = 1 at an edge, the state SHALL become IDLE, beat_cnt = 0 and last_owner = 1, so that IC wins the first tie.
REQ-034 During and after reset, every output SHALL be 0, including when reset is asserted mid-burst; the aborted burst SHALL produce no further grants.

Verification
REQ-035 Scenario: ic_rd_req=1 only, l2_ready=1 continuously -> ic_rd_granted high for 4 consecutive cycles starting 1 cycle after the request, then 1 IDLE cycle.
REQ-036 Scenario: ic_rd_req and dc_rd_req both raised in the same cycle after reset -> IC burst of 4 grants, 1 IDLE cycle, then DC burst of 4 grants; repeat the requests -> IC is served first again.
REQ-037 Scenario: dc_wr_req=1 and dc_rd_req=1 with dc_wr_data=0xDEADBEEF -> single dc_wr_granted with l2_wr_en=1 and l2_wr_data=0xDEADBEEF, then the DC read burst after the IDLE cycle.
REQ-038 Scenario: during an IC burst, l2_ready toggles 1,0,0,1,1,1 -> grants only in ready cycles, 4 grants total, l2_addr stable while stalled.
REQ-039 Scenario: dc_rd_req dropped after 2 grants -> FSM returns to IDLE next cycle, busy=0, no third grant, and a pending ic_rd_req is served next.
REQ-040 Scenario: rst asserted after the 2nd beat of a DC read -> all outputs 0 the next cycle and a new request starts with beat_cnt = 0.
